// File: rtl/proc_control_unit_pkg.sv
// Shared encodings for the bus-processor control unit: opcodes, ALU selects,
// sequencer states and instruction field geometry.
package proc_control_unit_pkg;

    localparam int OP_W   = 3;
    localparam int REG_W  = 3;
    localparam int SEL_W  = 3;
    localparam int STEP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } opcode_e;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_SLT = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101
    } alu_sel_e;

    localparam logic [SEL_W-1:0] ALU_IDLE = 3'b000;

    typedef enum logic [STEP_W-1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    // Field LSBs are measured down from the word MSB so DATA_W can grow.
    localparam int OP_OFS = OP_W;
    localparam int RX_OFS = OP_W + REG_W;
    localparam int RY_OFS = OP_W + 2 * REG_W;

    function automatic logic is_alu_op(opcode_e op);
        return (op != OP_MV) && (op != OP_MVI);
    endfunction

    function automatic logic [SEL_W-1:0] alu_sel(opcode_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            OP_SLL:  return ALU_SLL;
            OP_SRL:  return ALU_SRL;
            default: return ALU_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction input side plus every bus
// source/sink enable the sequencer drives.
interface proc_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              IRin;
    logic [NREGS-1:0]  Rout;
    logic [NREGS-1:0]  Rin;
    logic              DINout;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [2:0]        AluSel;
    logic              Done;

    modport master (
        output Run, DIN,
        input  IRin, Rout, Rin, DINout, Ain, Gin, Gout, AluSel, Done
    );

    modport slave (
        input  Run, DIN,
        output IRin, Rout, Rin, DINout, Ain, Gin, Gout, AluSel, Done
    );
endinterface

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit register field to one-hot enable, forced to zero when not enabled.
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);
    assign onehot_o = en_i ? (8'd1 << sel_i) : 8'd0;
endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle sequencer for the 16-bit bus processor: fetches on Run, then
// drives register/A/G/ALU enables over 1-3 execute steps and pulses Done.
module proc_control_unit
    import proc_control_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    proc_control_unit_if.slave cu
);

    localparam int OP_LSB = DATA_W - OP_OFS;
    localparam int RX_LSB = DATA_W - RX_OFS;
    localparam int RY_LSB = DATA_W - RY_OFS;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q;

    opcode_e          op;
    logic [REG_W-1:0] rx, ry;
    logic             alu_op;

    logic             irin, dinout, ain, gin, gout, done;
    logic             rout_en, rin_en;
    logic [REG_W-1:0] rout_sel, rin_sel;
    logic [SEL_W-1:0] sel;
    logic [7:0]       rout_oh, rin_oh;

    assign op     = opcode_e'(ir_q[OP_LSB +: OP_W]);
    assign rx     = ir_q[RX_LSB +: REG_W];
    assign ry     = ir_q[RY_LSB +: REG_W];
    assign alu_op = is_alu_op(op);

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[RY_LSB-1:0];

    // IR only captures in the fetch cycle, so DIN activity during execute is harmless.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T0 && cu.Run)
                ir_q <= cu.DIN;
        end
    end

    always_comb begin
        state_d  = T0;
        irin     = 1'b0;
        rout_en  = 1'b0;
        rout_sel = '0;
        rin_en   = 1'b0;
        rin_sel  = '0;
        dinout   = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        sel      = ALU_IDLE;
        done     = 1'b0;
        case (state_q)
            T0: begin
                irin    = cu.Run;
                state_d = cu.Run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en  = 1'b1;
                        rout_sel = ry;
                        rin_en   = 1'b1;
                        rin_sel  = rx;
                        done     = 1'b1;
                    end
                    OP_MVI: begin
                        dinout  = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = rx;
                        done    = 1'b1;
                    end
                    default: begin
                        rout_en  = 1'b1;
                        rout_sel = rx;
                        ain      = 1'b1;
                        state_d  = T2;
                    end
                endcase
            end
            // T2/T3 with a move opcode can only come from corruption: stay silent, return to fetch.
            T2: begin
                if (alu_op) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    gin      = 1'b1;
                    sel      = alu_sel(op);
                    state_d  = T3;
                end
            end
            T3: begin
                if (alu_op) begin
                    gout    = 1'b1;
                    rin_en  = 1'b1;
                    rin_sel = rx;
                    done    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    dec3to8 u_dec_rout (.en_i(rout_en), .sel_i(rout_sel), .onehot_o(rout_oh));
    dec3to8 u_dec_rin  (.en_i(rin_en),  .sel_i(rin_sel),  .onehot_o(rin_oh));

    // IRin is the only output that sees Run directly, so it alone needs the reset gate.
    assign cu.IRin   = irin & Resetn;
    assign cu.Rout   = rout_oh;
    assign cu.Rin    = rin_oh;
    assign cu.DINout = dinout;
    assign cu.Ain    = ain;
    assign cu.Gin    = gin;
    assign cu.Gout   = gout;
    assign cu.AluSel = sel;
    assign cu.Done   = done;

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed and randomized bench for proc_control_unit against a per-instruction step-table model.
module tb_proc_control_unit;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    proc_control_unit_if #(.DATA_W(DATA_W), .NREGS(NREGS)) bus ();

    proc_control_unit #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .cu    (bus.slave)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] obs;
    assign obs = {7'd0, bus.IRin, bus.Rout, bus.Rin, bus.DINout, bus.Ain, bus.Gin,
                  bus.Gout, bus.AluSel, bus.Done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vec(input bit irin, input logic [7:0] rout,
                                        input logic [7:0] rin, input bit dinout, input bit ain,
                                        input bit gin, input bit gout, input logic [2:0] sel,
                                        input bit done);
        return {7'd0, irin, rout, rin, dinout, ain, gin, gout, sel, done};
    endfunction

    // Expected execute-step outputs for one instruction, straight from the ISA table.
    task automatic model(input logic [15:0] ins, output logic [2:0][31:0] e, output int n);
        logic [2:0] op, rx, ry, sel;
        logic [7:0] rxh, ryh;
        op  = ins[15:13];
        rx  = ins[12:10];
        ry  = ins[9:7];
        rxh = 8'd1 << rx;
        ryh = 8'd1 << ry;
        case (op)
            3'd2:    sel = 3'd0;
            3'd3:    sel = 3'd1;
            3'd4:    sel = 3'd2;
            3'd5:    sel = 3'd3;
            3'd6:    sel = 3'd4;
            3'd7:    sel = 3'd5;
            default: sel = 3'd0;
        endcase
        e = '0;
        if (op == 3'd0) begin
            n = 1;
            e[0] = vec(0, ryh, rxh, 0, 0, 0, 0, 3'd0, 1);
        end else if (op == 3'd1) begin
            n = 1;
            e[0] = vec(0, 8'd0, rxh, 1, 0, 0, 0, 3'd0, 1);
        end else begin
            n = 3;
            e[0] = vec(0, rxh, 8'd0, 0, 1, 0, 0, 3'd0, 0);
            e[1] = vec(0, ryh, 8'd0, 0, 0, 1, 0, sel, 0);
            e[2] = vec(0, 8'd0, rxh, 0, 0, 0, 1, 3'd0, 1);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic run_instr(input logic [15:0] ins, input int idle, input bit noise);
        logic [2:0][31:0] e;
        int n;
        for (int i = 0; i < idle; i++) begin
            bus.Run = 1'b0;
            bus.DIN = 16'($urandom);
            @(negedge Clock);
            check("idle", obs, 32'd0);
            @(posedge Clock); #1;
        end
        bus.Run = 1'b1;
        bus.DIN = ins;
        @(negedge Clock);
        check($sformatf("fetch %h", ins), obs, vec(1, 8'd0, 8'd0, 0, 0, 0, 0, 3'd0, 0));
        @(posedge Clock); #1;
        model(ins, e, n);
        for (int k = 0; k < n; k++) begin
            bus.Run = noise ? 1'($urandom) : 1'b0;
            bus.DIN = noise ? 16'($urandom) : ins;
            @(negedge Clock);
            check($sformatf("step%0d %h", k + 1, ins), obs, e[k]);
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        bus.Run = 1'b1;
        bus.DIN = 16'h4500;
        #2;
        check("rst_out", obs, 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_hold", obs, 32'd0);
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        @(posedge Clock); #1;

        // Directed cases: mvi, mv, sub, srl back-to-back into add, rx==ry move.
        run_instr(16'h2800, 0, 0);
        run_instr(16'h0680, 1, 0);
        run_instr(16'h6380, 1, 0);
        run_instr(16'hF200, 1, 1);
        run_instr(16'h4500, 0, 1);
        run_instr(16'h0D80, 0, 0);
        run_instr(16'h2800, 10, 0);

        // Reset asserted mid-instruction, in the T2 step of an add.
        bus.Run = 1'b1;
        bus.DIN = 16'h4500;
        @(posedge Clock); #1;
        bus.Run = 1'b0;
        @(posedge Clock); #1;
        bus.Run = 1'b1;
        bus.DIN = 16'hFFFF;
        #1;
        check("mid_t2", obs, vec(0, 8'h04, 8'd0, 0, 0, 1, 0, 3'd0, 0));
        Resetn = 1'b0;
        #1;
        check("mid_rst", obs, 32'd0);
        @(posedge Clock); #1;
        check("mid_rst_hold", obs, 32'd0);
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        @(negedge Clock);
        check("post_rst_idle", obs, 32'd0);
        @(posedge Clock); #1;
        run_instr(16'h0680, 0, 0);

        for (int i = 0; i < 300; i++)
            run_instr(16'($urandom), $urandom_range(0, 2), 1);

        run_instr(16'h0000, 3, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
